// File: rtl/change_dispenser.sv
// Greedy coin payout engine: latches a change amount on start and issues it
// largest-coin-first, one coin per valid/ack handshake with the ejector.
module change_dispenser #(
    parameter int N      = 8,
    parameter int COIN_A = 50,
    parameter int COIN_B = 25,
    parameter int COIN_C = 10,
    parameter int COIN_D = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] amount,
    input  logic         coin_ack,
    output logic         coin_valid,
    output logic [1:0]   coin_sel,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] remainder,
    output logic [N-1:0] coin_count
);

    localparam logic [N-1:0] VA = N'(COIN_A);
    localparam logic [N-1:0] VB = N'(COIN_B);
    localparam logic [N-1:0] VC = N'(COIN_C);
    localparam logic [N-1:0] VD = N'(COIN_D);

    typedef enum logic [1:0] {S_IDLE, S_SELECT, S_ISSUE, S_DONE} state_t;

    state_t       state, state_n;
    logic [N-1:0] remaining, remaining_n;
    logic [N-1:0] count_n, remainder_n;
    logic         valid_n, busy_n, done_n;
    logic [1:0]   sel_n;

    function automatic logic [N-1:0] coin_value(input logic [1:0] s);
        case (s)
            2'd0:    return VA;
            2'd1:    return VB;
            2'd2:    return VC;
            default: return VD;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            remaining  <= '0;
            coin_valid <= 1'b0;
            coin_sel   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            remainder  <= '0;
            coin_count <= '0;
        end else begin
            state      <= state_n;
            remaining  <= remaining_n;
            coin_valid <= valid_n;
            coin_sel   <= sel_n;
            busy       <= busy_n;
            done       <= done_n;
            remainder  <= remainder_n;
            coin_count <= count_n;
        end
    end

    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        valid_n     = coin_valid;
        sel_n       = coin_sel;
        busy_n      = busy;
        done_n      = 1'b0;
        remainder_n = remainder;
        count_n     = coin_count;
        case (state)
            S_IDLE: begin
                if (start) begin
                    remaining_n = amount;
                    count_n     = '0;
                    busy_n      = 1'b1;
                    state_n     = S_SELECT;
                end
            end
            S_SELECT: begin
                // Priority order gives largest-first; a coin is only chosen if it fits
                if (remaining >= VA || remaining >= VB || remaining >= VC || remaining >= VD) begin
                    if (remaining >= VA)      sel_n = 2'd0;
                    else if (remaining >= VB) sel_n = 2'd1;
                    else if (remaining >= VC) sel_n = 2'd2;
                    else                      sel_n = 2'd3;
                    valid_n = 1'b1;
                    state_n = S_ISSUE;
                end else begin
                    remainder_n = remaining;
                    done_n      = 1'b1;
                    state_n     = S_DONE;
                end
            end
            S_ISSUE: begin
                if (coin_ack) begin
                    remaining_n = remaining - coin_value(coin_sel);
                    if (coin_count != '1) count_n = coin_count + 1'b1;
                    valid_n = 1'b0;
                    state_n = S_SELECT;
                end
            end
            S_DONE: begin
                busy_n  = 1'b0;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule
